// File: rtl/hub_pkg.sv
// hub_pkg: shared defaults, FSM state encoding and a constant clog2 helper for the hub scheduler.
package hub_pkg;
  localparam int NPORTS_DEF = 4;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FREE = 2'd1, LAUNCH = 2'd2, DRAIN = 2'd3} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/hub_rr_arbiter.sv
// hub_rr_arbiter: combinational round-robin pick of the first set val bit at or above ptr, wrapping; one-hot grant, binary idx, any.
module hub_rr_arbiter
  import hub_pkg::*;
#(
  parameter int N = NPORTS_DEF,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  val,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx,
  output logic          any
);
  logic [2*N-1:0] dbl;
  logic [SW:0] sum;
  always_comb begin
    dbl = {val, val} >> ptr;
    sum = '0;
    for (int k = N - 1; k >= 0; k--)
      if (dbl[k]) sum = {1'b0, ptr} + (SW + 1)'(k);
    if (sum >= (SW + 1)'(N)) sum = sum - (SW + 1)'(N);
    idx = sum[SW-1:0];
    any = |val;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/hub_scheduler.sv
// hub_scheduler: captures received bytes per port and broadcasts them round-robin to all other ports' transmitters (ports: clk, reset(active-low async), rec_complete/dout_bus/tr_free in, tr_start/din_bus out, busy/src_sel/ovf/timeout status, flag_clr).
module hub_scheduler
  import hub_pkg::*;
#(
  parameter int NPORTS = NPORTS_DEF,
  parameter int DW = DW_DEF,
  parameter int TO_CYCLES = 4096,
  localparam int SW = clog2(NPORTS),
  localparam int CW = clog2(TO_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    rec_complete,
  input  logic [NPORTS*DW-1:0] dout_bus,
  input  logic [NPORTS-1:0]    tr_free,
  output logic [NPORTS-1:0]    tr_start,
  output logic [NPORTS*DW-1:0] din_bus,
  output logic                 busy,
  output logic [SW-1:0]        src_sel,
  output logic [NPORTS-1:0]    ovf,
  output logic                 timeout,
  input  logic                 flag_clr
);
  state_t state_q, state_d;
  logic [NPORTS-1:0] rec_q, val_q, acc_q, acc_d, rise, grant, take_vec, dst;
  logic [NPORTS-1:0][DW-1:0] hold_q;
  logic [DW-1:0] txreg;
  logic [SW-1:0] ptr_q, gidx;
  logic [CW-1:0] cnt_q;
  logic any, take, all_free, all_acc, to_hit, set_to;
  hub_rr_arbiter #(.N(NPORTS), .SW(SW)) u_arb (
    .val(val_q),
    .ptr(ptr_q),
    .grant(grant),
    .idx(gidx),
    .any(any)
  );
  always_comb begin
    rise = rec_complete & ~rec_q;
    dst = ~(NPORTS'(1) << src_sel);
    // a destination counts as accepted from the first cycle its transmitter reports busy
    acc_d = acc_q | (dst & ~tr_free);
    all_free = (tr_free & dst) == dst;
    all_acc = acc_d == dst;
    to_hit = cnt_q == CW'(TO_CYCLES - 1);
    take = state_q == IDLE && any;
    take_vec = take ? grant : '0;
    busy = state_q != IDLE;
  end
  always_comb begin
    state_d = state_q;
    tr_start = '0;
    set_to = 1'b0;
    case (state_q)
      IDLE:      state_d = any ? WAIT_FREE : IDLE;
      WAIT_FREE: state_d = all_free ? LAUNCH : WAIT_FREE;
      LAUNCH: begin
        tr_start = dst & ~acc_q;
        set_to = !all_acc && to_hit;
        state_d = all_acc ? DRAIN : set_to ? IDLE : LAUNCH;
      end
      DRAIN:     state_d = all_free ? IDLE : DRAIN;
    endcase
  end
  always_comb begin
    din_bus = '0;
    for (int j = 0; j < NPORTS; j++)
      if ((state_q == LAUNCH || state_q == DRAIN) && dst[j]) din_bus[j*DW +: DW] = txreg;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_q <= '0;
      val_q <= '0;
      hold_q <= '0;
      txreg <= '0;
      src_sel <= '0;
      ptr_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf <= '0;
      timeout <= 1'b0;
    end else begin
      rec_q <= rec_complete;
      // a capture in the same cycle the slot is being selected refills it instead of overflowing
      val_q <= (val_q & ~take_vec) | rise;
      ovf <= (ovf & ~{NPORTS{flag_clr}}) | (rise & val_q & ~take_vec);
      timeout <= (timeout & ~flag_clr) | set_to;
      acc_q <= state_q == LAUNCH ? acc_d : '0;
      cnt_q <= state_q == LAUNCH ? cnt_q + 1'b1 : '0;
      for (int i = 0; i < NPORTS; i++)
        if (rise[i] && (!val_q[i] || take_vec[i])) hold_q[i] <= dout_bus[i*DW +: DW];
      if (take) begin
        src_sel <= gidx;
        txreg <= hold_q[gidx];
        ptr_q <= gidx == SW'(NPORTS - 1) ? '0 : gidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hub_scheduler.sv
// tb_hub_scheduler: randomized self-checking bench with port transmitter models and a broadcast-order scoreboard.
module tb_hub_scheduler;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] rec_complete, tr_free, tr_start, ovf;
  logic [N*8-1:0] dout_bus, din_bus;
  logic busy, timeout, flag_clr;
  logic [1:0] src_sel;
  int n_chk = 0, n_err = 0;
  int mptr = 0;
  logic [7:0] exp_b [N][64];
  logic [7:0] got_b [N][64];
  int exp_n [N];
  int got_n [N];
  int dly [N];
  int left [N];
  bit hold [N];

  hub_scheduler #(.NPORTS(N), .DW(8), .TO_CYCLES(16)) dut (
    .clk(clk),
    .reset(reset),
    .rec_complete(rec_complete),
    .dout_bus(dout_bus),
    .tr_free(tr_free),
    .tr_start(tr_start),
    .din_bus(din_bus),
    .busy(busy),
    .src_sel(src_sel),
    .ovf(ovf),
    .timeout(timeout),
    .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transmitter model: after seeing tr_start it goes busy (tr_free=0) after 0..2 cycles, latching din, for 1..4 cycles
  initial begin
    tr_free = '1;
    for (int j = 0; j < N; j++) begin dly[j] = 0; left[j] = 0; hold[j] = 0; end
    forever begin
      @(negedge clk);
      if (!reset) begin
        tr_free = '1;
        for (int j = 0; j < N; j++) begin dly[j] = 0; left[j] = 0; end
      end else
        for (int j = 0; j < N; j++) begin
          if (tr_free[j]) begin
            if (tr_start[j] && !hold[j]) begin
              if (dly[j] == 0) begin
                tr_free[j] = 1'b0;
                left[j] = int'($urandom_range(1, 4));
                dly[j] = int'($urandom_range(0, 2));
                if (got_n[j] < 64) got_b[j][got_n[j]] = din_bus[j*8 +: 8];
                got_n[j]++;
              end else dly[j]--;
            end
          end else if (left[j] <= 1) tr_free[j] = 1'b1;
          else left[j]--;
        end
    end
  end

  task automatic clear_sb();
    for (int j = 0; j < N; j++) begin exp_n[j] = 0; got_n[j] = 0; end
  endtask

  task automatic bcast(input int s, input logic [7:0] b);
    for (int j = 0; j < N; j++)
      if (j != s && exp_n[j] < 64) begin exp_b[j][exp_n[j]] = b; exp_n[j]++; end
  endtask

  task automatic check_sb(input string tag);
    for (int j = 0; j < N; j++) begin
      chk({tag, "_cnt"}, 32'(got_n[j]), 32'(exp_n[j]));
      for (int k = 0; k < exp_n[j] && k < got_n[j]; k++)
        chk({tag, "_byte"}, 32'(got_b[j][k]), 32'(exp_b[j][k]));
    end
  endtask

  task automatic fire(input logic [N-1:0] m, input logic [N*8-1:0] d);
    rec_complete = m;
    dout_bus = d;
    @(negedge clk);
    rec_complete = '0;
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    bit ok;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      if (busy === lvl) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk(tag, 32'(busy), 32'(lvl));
  endtask

  task automatic wait_done(input string tag);
    int z;
    z = 0;
    for (int c = 0; c < 600 && z < 3; c++) begin
      @(negedge clk);
      z = (!busy && &tr_free) ? z + 1 : 0;
    end
    chk(tag, 32'(z >= 3), 32'd1);
  endtask

  // expected broadcasts for bytes captured together: visit pending ports in order from the model pointer
  task automatic run_trial(input string tag, input logic [N-1:0] m, input logic [N*8-1:0] d,
                           input int op, input logic [7:0] ob, input bit clr);
    int p, last;
    clear_sb();
    last = 0;
    for (int k = 0; k < N; k++) begin
      p = (mptr + k) % N;
      if (m[p]) begin bcast(p, d[p*8 +: 8]); last = p; end
    end
    mptr = (last + 1) % N;
    fire(m, d);
    @(negedge clk);
    if (op >= 0) begin
      flag_clr = clr;
      fire(N'(1) << op, {N{ob}});
      flag_clr = 1'b0;
    end
    wait_done({tag, "_done"});
    check_sb(tag);
    chk({tag, "_ovf"}, 32'(ovf), op >= 0 ? 32'(1) << op : 32'd0);
    chk({tag, "_src"}, 32'(src_sel), 32'(last));
    chk({tag, "_to"}, 32'(timeout), 32'd0);
    if (op >= 0) begin
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      chk({tag, "_ovfclr"}, 32'(ovf), 32'd0);
    end
  endtask

  initial begin
    int a, b, cnt, first, op, seen;
    logic [N-1:0] m, others;
    logic [N*8-1:0] d;
    logic [7:0] ba, bb, bc;
    reset = 1'b0;
    rec_complete = '0;
    dout_bus = '0;
    flag_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start", 32'(tr_start), 32'd0);
    chk("rst_din", din_bus, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src", 32'(src_sel), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_busy", 32'(busy), 32'd0);

    clear_sb();
    bcast(0, 8'h47);
    fire(4'b0001, 32'h00000047);
    chk("sb_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("sb_busy1", 32'(busy), 32'd1);
    chk("sb_src", 32'(src_sel), 32'd0);
    chk("sb_nostart", 32'(tr_start), 32'd0);
    @(negedge clk);
    chk("sb_start", 32'(tr_start), 32'b1110);
    chk("sb_din", din_bus, 32'h47474700);
    wait_done("sb_done");
    check_sb("sb");
    chk("sb_din_idle", din_bus, 32'd0);
    mptr = 1;

    run_trial("rr", 4'b1110, 32'h03028100, -1, 8'h00, 0);
    run_trial("ovf", 4'b0110, 32'h00AA5500, 2, 8'hBB, 0);

    a = mptr;
    b = (mptr + 1) % N;
    ba = 8'($urandom);
    bb = 8'($urandom);
    bc = 8'($urandom);
    clear_sb();
    bcast(a, ba);
    bcast(b, bb);
    bcast(b, bc);
    d = '0;
    d[a*8 +: 8] = ba;
    d[b*8 +: 8] = bb;
    fire((N'(1) << a) | (N'(1) << b), d);
    wait_busy(1'b1, "col_rise");
    wait_busy(1'b0, "col_fall");
    fire(N'(1) << b, {N{bc}});
    chk("col_idle_once", 32'(busy), 32'd1);
    wait_done("col_done");
    check_sb("col");
    chk("col_ovf", 32'(ovf), 32'd0);
    chk("col_src", 32'(src_sel), 32'(b));
    mptr = (b + 1) % N;

    clear_sb();
    hold[3] = 1;
    bcast(0, 8'h5C);
    exp_n[3] = 0;
    fire(4'b0001, 32'h0000005C);
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      cnt += int'(tr_start[3]);
      @(negedge clk);
    end
    chk("to_len", 32'(cnt), 32'd16);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_start", 32'(tr_start), 32'd0);
    wait_done("to_done");
    check_sb("to");
    mptr = 1;
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("to_clr", 32'(timeout), 32'd0);
    hold[3] = 0;

    for (int t = 0; t < 40; t++) begin
      m = 4'($urandom_range(1, 15));
      d = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      first = 0;
      for (int k = N - 1; k >= 0; k--) if (m[(mptr + k) % N]) first = (mptr + k) % N;
      others = m & ~(N'(1) << first);
      op = -1;
      if (others != 0 && $urandom_range(0, 1) == 1) begin
        op = int'($urandom_range(0, N - 1));
        while (!others[op]) op = (op + 1) % N;
      end
      run_trial("rnd", m, d, op, ~d[7:0], 1'($urandom_range(0, 1)));
    end

    for (int j = 0; j < N; j++) hold[j] = 1;
    fire(4'b0100, 32'h00990000);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (tr_start != 0) seen = 1;
      else @(negedge clk);
    end
    chk("ar_launch", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_start", 32'(tr_start), 32'd0);
    chk("ar_din", din_bus, 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(negedge clk);
    for (int j = 0; j < N; j++) hold[j] = 0;
    reset = 1'b1;
    mptr = 0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("ar_val_clear", 32'(seen), 32'd0);
    chk("ar_ovf", 32'(ovf), 32'd0);
    chk("ar_src", 32'(src_sel), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
